// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the width of the post-load reset-hold counter.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERR
    } loader_state_t;

    localparam int HOLD_CW = 4;

    typedef logic [HOLD_CW-1:0] hold_cnt_t;

endpackage

// File: rtl/loader_cksum.sv
// 32-bit XOR accumulator used to build the running checksum of a loaded image.
module loader_cksum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= value ^ data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams an instruction image into the core's instruction memory, verifies an
// XOR checksum trailer, and holds the core in reset until the image is good.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h0,
    parameter int          HOLD  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Start,
    input  logic                       InValid,
    input  logic [31:0]                InData,
    input  logic                       InLast,
    output logic                       InReady,
    output logic                       IMWE,
    output logic [31:0]                IMWA,
    output logic [31:0]                IMWD,
    output logic                       CPURST,
    output logic                       Done,
    output logic                       Err,
    output logic [$clog2(DEPTH):0]     WordCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    loader_state_t state;
    loader_state_t next_state;
    hold_cnt_t     hold_cnt;
    logic          handshake;
    logic          has_room;
    logic          ck_clr;
    logic          ck_en;
    logic          wr;
    logic [31:0]   ck_value;

    assign handshake = InValid && InReady;
    assign has_room  = (WordCount < CW'(DEPTH));

    loader_cksum u_cksum (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (ck_clr),
        .en    (ck_en),
        .data  (InData),
        .value (ck_value)
    );

    // Status outputs depend on state only, so the core and upstream never see glitches from data inputs.
    always_comb begin
        InReady = (state == S_LOAD) || (state == S_CHECK);
        CPURST  = (state != S_RUN);
        Done    = (state == S_RUN);
        Err     = (state == S_ERR);
    end

    always_comb begin
        next_state = state;
        ck_clr     = 1'b0;
        ck_en      = 1'b0;
        wr         = 1'b0;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (Start) begin
                    next_state = S_LOAD;
                    ck_clr     = 1'b1;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    if (has_room) begin
                        wr    = 1'b1;
                        ck_en = 1'b1;
                        if (InLast) begin
                            next_state = S_CHECK;
                        end
                    end else begin
                        next_state = S_ERR;
                    end
                end
            end
            S_CHECK: begin
                if (handshake) begin
                    next_state = (InData == ck_value) ? S_HOLD : S_ERR;
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_CW'(HOLD - 1)) begin
                    next_state = S_RUN;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    // The memory port is registered so each accepted word is written exactly one cycle after its handshake.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            IMWE      <= 1'b0;
            IMWA      <= '0;
            IMWD      <= '0;
            WordCount <= '0;
        end else begin
            IMWE <= wr;
            if (wr) begin
                IMWA <= BASE + (32'(WordCount) << 2);
                IMWD <= InData;
            end
            if (ck_clr) begin
                WordCount <= '0;
            end else if (wr) begin
                WordCount <= WordCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a scoreboard queue holds the memory writes
// each accepted word must produce and a negedge monitor retires them.
module tb_imem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          HOLD  = 2;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Start = 1'b0;
    logic          InValid = 1'b0;
    logic [31:0]   InData = '0;
    logic          InLast = 1'b0;
    logic          InReady;
    logic          IMWE;
    logic [31:0]   IMWA;
    logic [31:0]   IMWD;
    logic          CPURST;
    logic          Done;
    logic          Err;
    logic [CW-1:0] WordCount;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    wr_t         expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] modelCk = '0;
    int          modelCount = 0;

    imem_loader #(.DEPTH(DEPTH), .BASE(BASE), .HOLD(HOLD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .InValid   (InValid),
        .InData    (InData),
        .InLast    (InLast),
        .InReady   (InReady),
        .IMWE      (IMWE),
        .IMWA      (IMWA),
        .IMWD      (IMWD),
        .CPURST    (CPURST),
        .Done      (Done),
        .Err       (Err),
        .WordCount (WordCount)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write on the memory port must match the oldest outstanding expectation, including its cycle.
    always @(negedge CLK) begin
        if (IMWE === 1'b1) begin
            checkOutput("write_pending", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                wr_t e;
                e = expq.pop_front();
                checkOutput("write_addr", IMWA, e.addr);
                checkOutput("write_data", IMWD, e.data);
                checkOutput("write_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic expectWrite);
        logic accepted;
        accepted = 1'b0;
        InValid  = 1'b1;
        InData   = data;
        InLast   = last;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge CLK);
            if (InReady === 1'b1) begin
                accepted = 1'b1;
                if (expectWrite) begin
                    expq.push_back('{BASE + 32'(4 * modelCount), data, cyc + 1});
                    modelCount++;
                    modelCk ^= data;
                end
            end
        end
        checkOutput("handshake_timeout", 32'(accepted), 32'd1);
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        InLast  = 1'b0;
        InData  = $urandom;
    endtask

    task automatic startSession();
        @(posedge CLK);
        #1 Start = 1'b1;
        modelCount = 0;
        modelCk    = '0;
        @(posedge CLK);
        #1 Start = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cpurst"}, 32'(CPURST), 32'd1);
        checkOutput({tag, "_imwe"}, 32'(IMWE), 32'd0);
        checkOutput({tag, "_imwa"}, IMWA, 32'd0);
        checkOutput({tag, "_imwd"}, IMWD, 32'd0);
        checkOutput({tag, "_done"}, 32'(Done), 32'd0);
        checkOutput({tag, "_err"}, 32'(Err), 32'd0);
        checkOutput({tag, "_wcount"}, 32'(WordCount), 32'd0);
        checkOutput({tag, "_inready"}, 32'(InReady), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] imem_loader bench start");
        #12;
        checkReset("reset");
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        checkOutput("idle_cpurst", 32'(CPURST), 32'd1);

        // Good three-word image followed by its checksum.
        startSession();
        applyStimulus(32'h20080005, 1'b0, 1'b1);
        applyStimulus(32'h20090003, 1'b0, 1'b1);
        applyStimulus(32'h01095020, 1'b1, 1'b1);
        applyStimulus(modelCk, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("hold0_cpurst", 32'(CPURST), 32'd1);
        @(negedge CLK);
        checkOutput("hold1_cpurst", 32'(CPURST), 32'd1);
        @(negedge CLK);
        checkOutput("run_cpurst", 32'(CPURST), 32'd0);
        checkOutput("run_done", 32'(Done), 32'd1);
        checkOutput("run_err", 32'(Err), 32'd0);
        checkOutput("run_wcount", 32'(WordCount), 32'd3);
        checkOutput("run_drained", 32'(expq.size()), 32'd0);

        // Restart from RUN, then a bad checksum.
        startSession();
        checkOutput("restart_cpurst", 32'(CPURST), 32'd1);
        checkOutput("restart_done", 32'(Done), 32'd0);
        checkOutput("restart_wcount", 32'(WordCount), 32'd0);
        applyStimulus(32'h20080005, 1'b0, 1'b1);
        applyStimulus(32'h20090003, 1'b0, 1'b1);
        applyStimulus(32'h01095020, 1'b1, 1'b1);
        applyStimulus(32'h00000000, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("badck_err", 32'(Err), 32'd1);
        checkOutput("badck_cpurst", 32'(CPURST), 32'd1);
        checkOutput("badck_done", 32'(Done), 32'd0);
        checkOutput("badck_wcount", 32'(WordCount), 32'd3);

        // Overflow: five words into a four-word memory.
        startSession();
        checkOutput("restart_err", 32'(Err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'hA5000000 + 32'(i), 1'b0, 1'b1);
        end
        applyStimulus(32'hDEADBEEF, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("ovf_err", 32'(Err), 32'd1);
        checkOutput("ovf_wcount", 32'(WordCount), 32'd4);
        checkOutput("ovf_inready", 32'(InReady), 32'd0);

        // Stalled upstream between two words; junk on InData/InLast must be ignored.
        startSession();
        applyStimulus(32'h11112222, 1'b0, 1'b1);
        InLast = 1'b1;
        InData = 32'hFFFFFFFF;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("stall_wcount", 32'(WordCount), 32'd1);
        checkOutput("stall_inready", 32'(InReady), 32'd1);
        applyStimulus(32'h33334444, 1'b1, 1'b1);
        applyStimulus(modelCk, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        checkOutput("stall_done", 32'(Done), 32'd1);
        checkOutput("stall_wcount_final", 32'(WordCount), 32'd2);

        // Asynchronous reset in the middle of a four-word image, then a full reload.
        startSession();
        applyStimulus(32'h0BADF00D, 1'b0, 1'b1);
        applyStimulus(32'h12345678, 1'b0, 1'b1);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checkReset("midreset");
        checkOutput("midreset_drained", 32'(expq.size()), 32'd0);
        @(negedge CLK) RST = 1'b1;
        startSession();
        applyStimulus(32'hCAFE0001, 1'b0, 1'b1);
        applyStimulus(32'hCAFE0002, 1'b0, 1'b1);
        applyStimulus(32'hCAFE0003, 1'b0, 1'b1);
        applyStimulus(32'hCAFE0004, 1'b1, 1'b1);
        applyStimulus(modelCk, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        checkOutput("reload_done", 32'(Done), 32'd1);
        checkOutput("reload_cpurst", 32'(CPURST), 32'd0);
        checkOutput("reload_wcount", 32'(WordCount), 32'd4);
        checkOutput("final_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
